// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the parallel-to-serial feeder: state encoding and the
// valid/ready transfer qualifier.
`ifndef SEQ_SERIALIZER_XFER
`define SEQ_SERIALIZER_XFER(valid, ready) ((valid) & (ready))
`endif

package seq_serializer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // IDLE: nothing held; SHIFT: shifter holds a word; FULL: shifter and buffer both hold words
    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_FULL  = ST_FULL
    } state_t;

endpackage

// File: rtl/seq_serializer.sv
// Serializes WIDTH-bit words one bit per enabled clock, with a one-word holding
// buffer so back-to-back words stream without an idle bit between them.
module seq_serializer
    import seq_serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             enable,
    output logic             data_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hbuf;
    logic [CW-1:0]    cnt;
    logic             xfer;
    logic             emit;
    logic             last_bit;
    logic             head;
    logic             load_sh_din;
    logic             load_sh_buf;
    logic             load_buf;

    assign din_ready = (state != S_FULL);
    assign busy      = (state != S_IDLE);
    assign xfer      = `SEQ_SERIALIZER_XFER(din_valid, din_ready);
    assign emit      = (state != S_IDLE) && enable;
    assign last_bit  = emit && (cnt == CNT_ONE);
    assign head      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        load_sh_din = 1'b0;
        load_sh_buf = 1'b0;
        load_buf    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (xfer) begin
                    load_sh_din = 1'b1;
                    state_nx    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A word arriving with the last bit goes straight into the shifter
                if (last_bit) begin
                    if (xfer) begin
                        load_sh_din = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else if (xfer) begin
                    load_buf = 1'b1;
                    state_nx = S_FULL;
                end
            end
            S_FULL: begin
                if (last_bit) begin
                    load_sh_buf = 1'b1;
                    state_nx    = S_SHIFT;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg       <= '0;
            hbuf        <= '0;
            cnt         <= '0;
            data_out    <= IDLE_LEVEL;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            bit_valid   <= emit;
            frame_start <= emit && (cnt == CNT_FULL);
            if (emit) begin
                data_out <= head;
            end
            if (load_sh_din) begin
                shreg <= din;
                cnt   <= CNT_FULL;
            end else if (load_sh_buf) begin
                shreg <= hbuf;
                cnt   <= CNT_FULL;
            end else if (emit) begin
                shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                cnt   <= cnt - CNT_ONE;
            end
            if (load_buf) begin
                hbuf <= din;
            end
        end
    end

endmodule
